// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
// Used by rr_pick_8 and rr_arbiter_8.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_pick_8.sv
// Combinational rotate-and-priority-encode picker.
// Scans req starting at ptr and wrapping modulo 8.
module rr_pick_8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               found_o
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W-1:0]      offset;

    // Doubling the vector turns the circular scan into a plain slice.
    assign req_dbl = {req_i, req_i};
    assign req_rot = req_dbl[ptr_i +: NUM_REQ];
    assign found_o = |req_i;

    always_comb begin
        offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = ID_W'(k);
            end
        end
    end

    // 3-bit addition wraps naturally back into the 0..7 index range.
    assign idx_o = ptr_i + offset;

    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_o] = found_o;
    end

endmodule : rr_pick_8

// File: rtl/rr_arbiter_8.sv
// Two-state round-robin arbiter for 8 requesters with registered grant outputs.
// Optional grant timeout enabled by defining RR_ARB_TIMEOUT_EN (uses MAX_HOLD).
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               release_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               grant_valid_o,
    output logic [ID_W-1:0]    grant_id_o,
    output logic               any_req_o,
    output logic               timeout_o
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_8: MAX_HOLD must be within 2..255");
    end

    arb_state_t           state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 grant_valid_q;
    logic [ID_W-1:0]      grant_id_q;
    logic [ID_W-1:0]      ptr_q;
    logic [ID_W-1:0]      ptr_d;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_found;
    logic                 vol_exit;
    logic                 tmo_hit;

    rr_pick_8 u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    assign vol_exit = release_i || !req_i[grant_id_q];
    assign ptr_d    = grant_id_q + 1'b1;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q;
    logic       timeout_q;

    assign tmo_hit   = (hold_q == HOLD_LAST);
    assign timeout_o = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            ptr_q         <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_q        <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q       <= GRANT;
                        grant_q       <= pick_onehot;
                        grant_valid_q <= 1'b1;
                        grant_id_q    <= pick_idx;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_q        <= '0;
`endif
                    end
                end
                GRANT: begin
                    // Other requesters are ignored until the grantee leaves.
                    if (vol_exit || tmo_hit) begin
                        state_q       <= IDLE;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        ptr_q         <= ptr_d;
`ifdef RR_ARB_TIMEOUT_EN
                        timeout_q     <= tmo_hit && !vol_exit;
`endif
                    end else begin
`ifdef RR_ARB_TIMEOUT_EN
                        hold_q <= hold_q + 8'd1;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = grant_valid_q;
    assign grant_id_o    = grant_id_q;
    assign any_req_o     = pick_found;

endmodule : rr_arbiter_8

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: a behavioural model predicts each cycle,
// a monitor compares DUT outputs one cycle later.
module tb_rr_arbiter_8;

    localparam int TB_MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic       any_req;
    logic       timeout;

    rr_arbiter_8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req),
        .release_i     (rel),
        .grant_o       (grant),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id),
        .any_req_o     (any_req),
        .timeout_o     (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] grant;
        logic       valid;
        logic [2:0] id;
        logic       tmo;
        logic       any;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: who owns the bus, where the next scan starts, how long held.
    int   m_owner = -1;
    int   m_start = 0;
    int   m_last  = 0;
    int   m_held  = 0;
    bit   m_tmo   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic drive(input logic r_n, input logic [7:0] r, input logic rl);
        exp_t e;
        bit   done;
        bit   timed;
        @(negedge clk);
        rst_n = r_n;
        req   = r;
        rel   = rl;
        if (!r_n) begin
            m_owner = -1; m_start = 0; m_last = 0; m_held = 0; m_tmo = 0;
        end else if (m_owner < 0) begin
            m_tmo = 0;
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && r[(m_start + k) % 8]) begin
                    m_owner = (m_start + k) % 8;
                end
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_held = 0;
            end
        end else begin
            done  = rl || !r[m_owner];
`ifdef RR_ARB_TIMEOUT_EN
            timed = (m_held == TB_MAX_HOLD - 1);
`else
            timed = 0;
`endif
            if (done || timed) begin
                m_start = (m_owner + 1) % 8;
                m_tmo   = timed && !done;
                m_owner = -1;
            end else begin
                m_held++;
                m_tmo = 0;
            end
        end
        e.grant = 8'h00;
        if (m_owner >= 0) e.grant[m_owner] = 1'b1;
        e.valid = (m_owner >= 0);
        e.id    = 3'(m_last);
        e.tmo   = m_tmo;
        e.any   = |r;
        sb.push_back(e);
    endtask

    // Monitor: compares one expected entry per clock, sampled just after the edge.
    initial begin
        exp_t e;
        logic prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("grant", grant, e.grant);
                check("grant_valid", {7'd0, grant_valid}, {7'd0, e.valid});
                check("grant_id", {5'd0, grant_id}, {5'd0, e.id});
                check("timeout", {7'd0, timeout}, {7'd0, e.tmo});
                check("any_req", {7'd0, any_req}, {7'd0, e.any});
                check("onehot", {7'd0, $countones(grant) <= 1}, 8'd1);
                if (grant_valid && !prev_valid) begin
                    txn++;
                    $display("txn %0d: t=%0t req=%02h grant=%02h id=%0d", txn, $time, req, grant, grant_id);
                end
                prev_valid = grant_valid;
            end
        end
    end

    initial begin
        logic [7:0] r;
        rst_n = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;

        drive(0, 8'h00, 0);
        drive(0, 8'hFF, 1);
        // Single requester, then release: next scan starts at 3.
        drive(1, 8'h04, 0);
        drive(1, 8'h04, 0);
        drive(1, 8'h04, 1);
        drive(1, 8'h00, 1);
        drive(1, 8'h0C, 0);
        drive(1, 8'h00, 0);
        drive(1, 8'h00, 0);
        // Full load with a release every second grant cycle.
        drive(0, 8'h00, 0);
        for (int i = 0; i < 30; i++) begin
            drive(1, 8'hFF, (m_owner >= 0 && m_held == 1));
        end
        drive(1, 8'h00, 0);
        drive(1, 8'h00, 0);
        // Wrap scan from pointer 5.
        drive(1, 8'h10, 0);
        drive(1, 8'h10, 1);
        drive(1, 8'h03, 0);
        drive(1, 8'h03, 1);
        drive(1, 8'h00, 0);
        drive(1, 8'h10, 0);
        drive(1, 8'h10, 1);
        drive(1, 8'h81, 0);
        // Grantee drops req; other bits must not disturb the grant.
        drive(1, 8'h7E, 0);
        drive(1, 8'h00, 0);
        drive(1, 8'h00, 0);
        drive(1, 8'h02, 0);
        drive(1, 8'hFE, 0);
        drive(1, 8'h3E, 0);
        drive(1, 8'hFD, 0);
        drive(1, 8'h00, 0);
        // Long hold: held indefinitely, or repeated timeouts when enabled.
        for (int i = 0; i < 120; i++) begin
            drive(1, 8'h01, 0);
        end
        // Release coinciding with the would-be timeout edge.
        drive(1, 8'h00, 0);
        drive(1, 8'h00, 0);
        drive(1, 8'h01, 0);
        for (int i = 0; i < TB_MAX_HOLD - 1; i++) drive(1, 8'h01, 0);
        drive(1, 8'h01, 1);
        drive(1, 8'h00, 0);
        // Reset in the middle of a grant.
        drive(1, 8'hFF, 0);
        drive(1, 8'hFF, 0);
        drive(0, 8'hFF, 0);
        drive(1, 8'hFF, 0);
        drive(1, 8'hFF, 1);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r = 8'($urandom);
            if ($urandom_range(3) == 0) r = 8'h00;
            drive(($urandom_range(63) != 0), r, ($urandom_range(3) == 0));
        end

        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rr_arbiter_8
